// File: rtl/uart_rx_pkg.sv
// Shared comm definitions: receiver state encoding and default bit timing.
package uart_rx_pkg;

  // 50 MHz clock / 115200 baud
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver result bundle: received byte plus status pulses.
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic       rx_ready;
  logic [7:0] rx_byte;
  logic       framing_err;
  logic       busy;

  modport master (output rx_ready, output rx_byte, output framing_err, output busy);
  modport slave  (input  rx_ready, input  rx_byte, input  framing_err, input  busy);
endinterface

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous input; flops reset high.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the async input through the flop chain
  always_ff @(posedge clk) begin
    if (reset) ff <= '1;
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, framing error detection, break hold-off.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx,
  uart_rx_if.master rx_if
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

  logic line;

  uart_rx_state_t state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [2:0]     index_q, index_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     byte_q, byte_d;
  logic           ready_q, ready_d;
  logic           ferr_q, ferr_d;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (line)
  );

  // State, timer, data and registered output pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      index_q <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      index_q <= index_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state, bit timing, sampling and pulse generation
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    index_d = index_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    ready_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!line) state_d = START;
      end
      START: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          index_d = '0;
          state_d = line ? IDLE : DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (timer_q == BIT_LAST) begin
          shift_d[index_q] = line;
          timer_d = '0;
          index_d = index_q + 3'd1;
          if (index_q == 3'd7) state_d = STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (line) begin
            byte_d  = shift_q;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      BREAK: begin
        if (line) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_if.rx_ready    = ready_q;
  assign rx_if.rx_byte     = byte_q;
  assign rx_if.framing_err = ferr_q;
  assign rx_if.busy        = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200 baud); legal range 4..65535.
REQ-002 Parameter SYNC_STAGES, default 2, number of flops in the rx input synchronizer; legal range 2..3.
REQ-003 Port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port rx, input, 1, asynchronous serial line; idle high; 8N1 frames, LSB first.
REQ-006 Port rx_ready, output, 1, one-cycle pulse when rx_byte holds a newly received valid byte.
REQ-007 Port rx_byte, output, 8, last good byte; held stable until the next good frame completes.
REQ-008 Port framing_err, output, 1, one-cycle pulse when the stop bit samples low.
REQ-009 Port busy, output, 1, high in every state except IDLE.

Function
REQ-010 rx SHALL pass through SYNC_STAGES flops; "line" below means the synchronizer output.
REQ-011 The FSM SHALL use states IDLE, START, DATA, STOP, BREAK.
REQ-012 IDLE: when line=0, SHALL go to START and clear the bit-timer to 0.
REQ-013 START: at timer = CLKS_PER_BIT/2 - 1 (floor), SHALL sample line.
- Sample 0: go to DATA, clear the timer and bit index.
- Sample 1 (glitch): go to IDLE with no output pulse.
REQ-014 DATA: at timer = CLKS_PER_BIT-1, SHALL sample line into shift-register bit[index], clear the timer, and increment index.
- After index 7 is sampled, go to STOP.
REQ-015 STOP: at timer = CLKS_PER_BIT-1, SHALL sample line.
- Sample 1: load rx_byte from the shift register, pulse rx_ready for exactly one cycle, go to IDLE.
- Sample 0: pulse framing_err for one cycle, leave rx_byte unchanged, go to BREAK.
REQ-016 BREAK: SHALL remain until line=1, then go to IDLE; no pulses while in BREAK.
REQ-017 rx_ready and framing_err SHALL be registered and SHALL never be high in the same cycle.
REQ-018 The timer SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL never count past CLKS_PER_BIT-1.
REQ-019 Latency: rx_ready rises exactly SYNC_STAGES + 1 cycles after the stop-bit mid-point on rx. The stop-bit mid-point is at CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the rx falling edge.
REQ-020 A new start bit SHALL be accepted in the cycle immediately after returning to IDLE, so back-to-back frames lose no bytes.
REQ-021 No downstream back-pressure exists; the consumer SHALL take rx_byte within CLKS_PER_BIT*10 cycles of rx_ready.

Reset
REQ-022 On reset, the FSM SHALL go to IDLE and timer/index SHALL clear. Outputs SHALL reset to rx_ready=0, framing_err=0, busy=0, rx_byte=8'h00.
REQ-023 Synchronizer flops SHALL reset to 1 (idle line).
REQ-024 Reset mid-frame SHALL discard the partial byte and emit no pulse; reception resumes on the next falling edge after reset deasserts.

Structure
REQ-025 The state enum (uart_rx_state_t) and the default CLKS_PER_BIT constant SHALL live in the shared comm package, so the transmitter and control logic use the same values.
REQ-026 The input synchronizer SHALL be the sub-module sync_bit (parameter STAGES, reset value 1), which is reusable for other async inputs.

Verification (bench uses CLKS_PER_BIT=16, SYNC_STAGES=2)
REQ-027 Send 0xA5 with a valid stop bit -> exactly one rx_ready pulse, rx_byte=0xA5, framing_err stays 0, busy returns to 0.
REQ-028 Send 0x00, 0xFF, 0x3C back-to-back with no idle gap -> three rx_ready pulses carrying 0x00, 0xFF, 0x3C in order.
REQ-029 Drive rx low for 5 cycles, then high -> no rx_ready, no framing_err, FSM back in IDLE.
REQ-030 Send 0x55 with the stop bit low, hold rx low 40 cycles, then send 0x81 -> one framing_err pulse, rx_byte stays at its prior value through BREAK, then rx_ready with rx_byte=0x81.
REQ-031 Assert reset at the mid-point of data bit 4 of 0xC3 -> no pulse, all outputs at reset values; a following 0x12 is received correctly.
REQ-032 Send 0x5A while checking rx_ready timing -> rx_ready rises exactly at the REQ-019 cycle: 8 + 144 + 3 = 155 cycles after the rx falling edge.
